// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the KGP-miniRISC multi-cycle controller and its datapath.
interface mc_control_fsm_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3,
  parameter int CNTW   = 32
);
  logic [OPW-1:0]    opcode;
  logic              mem_ack;
  logic              flag_zero;
  logic              flag_neg;
  logic              flag_carry;
  logic              resume;
  logic              mem_req;
  logic              mem_we;
  logic              ad_sel;
  logic              ir_write;
  logic              pc_write;
  logic [1:0]        pc_src;
  logic              reg_write;
  logic              reg_sel;
  logic              data_pc_sel;
  logic              mem_to_reg;
  logic [1:0]        alu_in_sel;
  logic [ALUOPW-1:0] alu_op;
  logic              halted;
  logic              illegal;
  logic              bus_err;
  logic [CNTW-1:0]   instr_count;

  // Controller side
  modport master (
    input  opcode, mem_ack, flag_zero, flag_neg, flag_carry, resume,
    output mem_req, mem_we, ad_sel, ir_write, pc_write, pc_src, reg_write, reg_sel,
           data_pc_sel, mem_to_reg, alu_in_sel, alu_op, halted, illegal, bus_err, instr_count
  );

  // Datapath / memory side
  modport slave (
    output opcode, mem_ack, flag_zero, flag_neg, flag_carry, resume,
    input  mem_req, mem_we, ad_sel, ir_write, pc_write, pc_src, reg_write, reg_sel,
           data_pc_sel, mem_to_reg, alu_in_sel, alu_op, halted, illegal, bus_err, instr_count
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for KGP-miniRISC: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshake timeout, flag-based branches, halt/resume and a retired-instruction counter.
module mc_control_fsm #(
  parameter int OPW         = 6,
  parameter int ALUOPW      = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 32
) (
  input logic             clk,
  input logic             reset,
  mc_control_fsm_if.master bus
);

  localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6);
  localparam logic [OPW-1:0] OP_SW   = OPW'(7);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(62);
  localparam logic [OPW-1:0] OP_HALT = OPW'(63);
  localparam logic [OPW-1:0] OP_LIM  = OPW'(16);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state, next_state;
  logic [WW-1:0]   wait_cnt;
  logic            illegal_q, bus_err_q;
  logic [CNTW-1:0] count_q;
  logic            retire, set_illegal, set_bus_err, clr_flags;
  logic            wait_last;

  assign wait_last       = (wait_cnt == WW'(MEM_TIMEOUT - 1));
  assign bus.illegal     = illegal_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.instr_count = count_q;

  // State, wait counter, sticky flags and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state <= next_state;
      // Staying put in FETCH/MEM only happens on a non-ack cycle; any transition restarts the count
      if ((state == S_FETCH || state == S_MEM) && next_state == state)
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;
      if (clr_flags) begin
        illegal_q <= 1'b0;
        bus_err_q <= 1'b0;
      end else begin
        if (set_illegal) illegal_q <= 1'b1;
        if (set_bus_err) bus_err_q <= 1'b1;
      end
      if (retire) count_q <= count_q + CNTW'(1);
    end
  end

  // Next-state and per-state datapath enables
  always_comb begin
    next_state      = state;
    retire          = 1'b0;
    set_illegal     = 1'b0;
    set_bus_err     = 1'b0;
    clr_flags       = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.ad_sel      = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 2'b00;
    bus.reg_write   = 1'b0;
    bus.reg_sel     = 1'b0;
    bus.data_pc_sel = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_in_sel  = 2'b00;
    bus.alu_op      = '0;
    bus.halted      = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next_state   = S_DECODE;
        end else if (wait_last) begin
          set_bus_err = 1'b1;
          next_state  = S_HALT;
        end
      end
      S_DECODE: begin
        if (bus.opcode == OP_HALT) begin
          retire     = 1'b1;
          next_state = S_HALT;
        end else if (bus.opcode == OP_NOP) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (bus.opcode < OP_LIM) begin
          next_state = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          next_state  = S_HALT;
        end
      end
      S_EXEC: begin
        // Upper opcode bits are known zero here: DECODE only enters EXEC for 0..15
        case (bus.opcode[3:0])
          4'd0: begin
            bus.alu_op = ALUOPW'(3'b111);
            next_state = S_WB;
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
            bus.alu_in_sel = 2'b01;
            bus.alu_op     = ALUOPW'(bus.opcode[3:0] - 4'd1);
            next_state     = S_WB;
          end
          4'd6, 4'd7: begin
            bus.alu_in_sel = 2'b01;
            next_state     = S_MEM;
          end
          4'd11: begin
            bus.pc_src   = 2'b10;
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            next_state   = S_FETCH;
          end
          4'd15: begin
            bus.pc_src      = 2'b01;
            bus.pc_write    = 1'b1;
            bus.reg_write   = 1'b1;
            bus.reg_sel     = 1'b1;
            bus.data_pc_sel = 1'b1;
            retire          = 1'b1;
            next_state      = S_FETCH;
          end
          default: begin
            bus.pc_src = 2'b01;
            case (bus.opcode[3:0])
              4'd8:    bus.pc_write = bus.flag_neg;
              4'd9:    bus.pc_write = bus.flag_zero;
              4'd10:   bus.pc_write = ~bus.flag_zero;
              4'd13:   bus.pc_write = bus.flag_carry;
              4'd14:   bus.pc_write = ~bus.flag_carry;
              default: bus.pc_write = 1'b1;
            endcase
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.ad_sel  = 1'b1;
        bus.mem_we  = (bus.opcode == OP_SW);
        if (bus.mem_ack) begin
          if (bus.opcode == OP_SW) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (wait_last) begin
          set_bus_err = 1'b1;
          next_state  = S_HALT;
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (bus.opcode == OP_LW);
        retire         = 1'b1;
        next_state     = S_FETCH;
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (bus.resume) begin
          clr_flags  = 1'b1;
          next_state = S_FETCH;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm: an instruction-level model predicts
// the enable pattern of every cycle, plus retire count and sticky flags.
module tb_mc_control_fsm;
  localparam int OPW = 6, ALUOPW = 3, TO = 4, CNTW = 4;

  typedef struct packed {
    logic       mem_req, mem_we, ad_sel, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_sel, data_pc_sel, mem_to_reg;
    logic [1:0] alu_in_sel;
    logic [2:0] alu_op;
    logic       halted;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.OPW(OPW), .ALUOPW(ALUOPW), .CNTW(CNTW)) bus ();
  mc_control_fsm #(.OPW(OPW), .ALUOPW(ALUOPW), .MEM_TIMEOUT(TO), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int          checks = 0, failures = 0;
  int unsigned exp_count = 0;
  bit          exp_ill = 0, exp_berr = 0;
  bit          fixed_flags = 0;
  bit          fz = 0, fn = 0, fc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t o;
    o.mem_req = bus.mem_req;  o.mem_we = bus.mem_we;  o.ad_sel = bus.ad_sel;
    o.ir_write = bus.ir_write; o.pc_write = bus.pc_write; o.pc_src = bus.pc_src;
    o.reg_write = bus.reg_write; o.reg_sel = bus.reg_sel; o.data_pc_sel = bus.data_pc_sel;
    o.mem_to_reg = bus.mem_to_reg; o.alu_in_sel = bus.alu_in_sel; o.alu_op = bus.alu_op;
    o.halted = bus.halted;
    return o;
  endfunction

  task automatic rand_inputs();
    bus.resume = 1'($urandom_range(0, 1));
    if (fixed_flags) begin
      bus.flag_zero = fz; bus.flag_neg = fn; bus.flag_carry = fc;
    end else begin
      bus.flag_zero = 1'($urandom_range(0, 1));
      bus.flag_neg = 1'($urandom_range(0, 1));
      bus.flag_carry = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock cycle: drive ack, compare enables at the falling edge, advance past the rising edge
  task automatic step(input string tag, input ctl_t e, input bit ack);
    bus.mem_ack = ack;
    @(negedge clk);
    check(tag, 32'(observed()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(bus.instr_count), exp_count % (1 << CNTW));
    check({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_ill));
    check({tag, "_bus_err"}, 32'(bus.bus_err), 32'(exp_berr));
  endtask

  function automatic ctl_t exec_exp(input int unsigned op);
    ctl_t e = '0;
    case (op)
      0: e.alu_op = 3'b111;
      1, 2, 3, 4, 5: begin e.alu_in_sel = 2'b01; e.alu_op = 3'(op - 1); end
      6, 7: e.alu_in_sel = 2'b01;
      8:  begin e.pc_src = 2'b01; e.pc_write = bus.flag_neg; end
      9:  begin e.pc_src = 2'b01; e.pc_write = bus.flag_zero; end
      10: begin e.pc_src = 2'b01; e.pc_write = !bus.flag_zero; end
      11: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      12: begin e.pc_src = 2'b01; e.pc_write = 1'b1; end
      13: begin e.pc_src = 2'b01; e.pc_write = bus.flag_carry; end
      14: begin e.pc_src = 2'b01; e.pc_write = !bus.flag_carry; end
      default: begin
        e.pc_src = 2'b01; e.pc_write = 1'b1; e.reg_write = 1'b1;
        e.reg_sel = 1'b1; e.data_pc_sel = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Sit in HALT for extra cycles, then resume; flags clear on the way back to FETCH
  task automatic do_halt(input int unsigned extra);
    ctl_t e = '0;
    e.halted = 1'b1;
    check_status("halt");
    for (int unsigned k = 0; k < extra; k++) begin
      rand_inputs(); bus.resume = 1'b0;
      step("halt_wait", e, 1'($urandom_range(0, 1)));
    end
    rand_inputs(); bus.resume = 1'b1;
    step("halt_resume", e, 1'($urandom_range(0, 1)));
    bus.resume = 1'b0;
    exp_ill = 0;
    exp_berr = 0;
  endtask

  // One instruction starting in FETCH; fd/md = ack delay in FETCH/MEM (>= TO means timeout)
  task automatic run_instr(input int unsigned op, input int unsigned fd, input int unsigned md,
                           input int unsigned hw);
    ctl_t e;
    bus.opcode = OPW'(op);
    check_status("fetch");
    for (int unsigned i = 0; i < TO; i++) begin
      rand_inputs(); e = '0; e.mem_req = 1'b1;
      if (i == fd) begin
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        step("fetch_ack", e, 1'b1);
        break;
      end
      step("fetch_wait", e, 1'b0);
      if (i == TO - 1) begin
        exp_berr = 1;
        do_halt(hw);
        return;
      end
    end
    rand_inputs(); e = '0;
    step("decode", e, 1'($urandom_range(0, 1)));
    if (op == 63) begin exp_count++; do_halt(hw); return; end
    if (op == 62) begin exp_count++; return; end
    if (op > 15) begin exp_ill = 1; do_halt(hw); return; end
    rand_inputs(); e = exec_exp(op);
    step("exec", e, 1'($urandom_range(0, 1)));
    if (op >= 8) begin exp_count++; return; end
    if (op == 6 || op == 7) begin
      for (int unsigned i = 0; i < TO; i++) begin
        rand_inputs(); e = '0; e.mem_req = 1'b1; e.ad_sel = 1'b1; e.mem_we = (op == 7);
        if (i == md) begin
          step("mem_ack", e, 1'b1);
          break;
        end
        step("mem_wait", e, 1'b0);
        if (i == TO - 1) begin
          exp_berr = 1;
          do_halt(hw);
          return;
        end
      end
      if (op == 7) begin exp_count++; return; end
    end
    rand_inputs(); e = '0; e.reg_write = 1'b1; e.mem_to_reg = (op == 6);
    step("wb", e, 1'($urandom_range(0, 1)));
    exp_count++;
  endtask

  initial begin
    ctl_t e;
    int unsigned r, op, fd, md;
    reset = 1'b1;
    bus.opcode = '0; bus.mem_ack = 1'b0; bus.resume = 1'b0;
    bus.flag_zero = 1'b0; bus.flag_neg = 1'b0; bus.flag_carry = 1'b0;
    #12;
    check("reset_outputs", 32'(observed()), 32'(0));
    check_status("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    step("idle", '0, 1'b1);

    run_instr(1, 1, 0, 0);
    run_instr(6, 0, 3, 0);
    run_instr(7, 0, 1, 0);
    fixed_flags = 1; fz = 1; fn = 0; fc = 0;
    run_instr(9, 0, 0, 0);
    fz = 0;
    run_instr(9, 0, 0, 0);
    fixed_flags = 0;
    run_instr(15, 0, 0, 0);
    run_instr(32, 0, 0, 2);
    run_instr(0, TO + 3, 0, 1);
    run_instr(1, TO - 1, 0, 0);
    run_instr(6, 0, TO - 1, 0);
    run_instr(6, 0, TO, 0);
    run_instr(63, 0, 0, 1);

    // Asynchronous reset while waiting in MEM
    bus.opcode = OPW'(6);
    rand_inputs(); e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step("rst_fetch", e, 1'b1);
    rand_inputs(); step("rst_decode", '0, 1'b0);
    rand_inputs(); step("rst_exec", exec_exp(6), 1'b0);
    bus.mem_ack = 1'b0;
    #1;
    e = '0; e.mem_req = 1'b1; e.ad_sel = 1'b1;
    check("rst_in_mem", 32'(observed()), 32'(e));
    #1 reset = 1'b1;
    #1;
    check("rst_async_outputs", 32'(observed()), 32'(0));
    exp_count = 0; exp_ill = 0; exp_berr = 0;
    check_status("rst_async");
    @(posedge clk); #1;
    reset = 1'b0;
    step("idle2", '0, 1'b1);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 21);
      if (r < 16) op = r;
      else if (r == 16) op = 62;
      else if (r == 17) op = 63;
      else if (r == 18) op = $urandom_range(16, 61);
      else op = $urandom_range(6, 7);
      fd = ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
      md = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
      run_instr(op, fd, md, $urandom_range(0, 3));
    end
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
